// File: rtl/sine_phase_gen.sv
// Phase-accumulator front end for the sine LUT: produces a registered table address
// and a per-sample valid strobe, with tuning-word changes deferred to accumulator wraps.
module sine_phase_gen #(
   parameter int ACC_W  = 32,
   parameter int ADDR_W = 10,
   parameter int DIV_W  = 16
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_en,
   input  logic [ACC_W-1:0]  i_ftw,
   input  logic              i_ftw_wr,
   input  logic [ADDR_W-1:0] i_phase_ofs,
   input  logic [DIV_W-1:0]  i_div,
   output logic [ADDR_W-1:0] o_addr,
   output logic              o_valid,
   output logic              o_wrap,
   output logic              o_ftw_pend
);

   localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

   logic [ACC_W-1:0]  acc_q,        acc_d;
   logic [ACC_W-1:0]  ftw_act_q,    ftw_act_d;
   logic [ACC_W-1:0]  ftw_shadow_q, ftw_shadow_d;
   logic [DIV_W-1:0]  div_cnt_q,    div_cnt_d;
   logic [ADDR_W-1:0] addr_q,       addr_d;
   logic              valid_q,      valid_d;
   logic              wrap_q,       wrap_d;
   logic              pend_q,       pend_d;

   logic              tick;
   logic [ACC_W:0]    acc_sum;
   logic              carry;
   logic              xfer_ok;

   always_comb begin
      // NOTE: every next-state signal takes its held value first, so no path can infer a latch.
      acc_d        = acc_q;
      ftw_act_d    = ftw_act_q;
      ftw_shadow_d = ftw_shadow_q;
      div_cnt_d    = div_cnt_q;
      addr_d       = addr_q;
      valid_d      = 1'b0;
      wrap_d       = 1'b0;
      pend_d       = pend_q;

      tick    = i_en && (div_cnt_q >= i_div);
      acc_sum = {1'b0, acc_q} + {1'b0, ftw_act_q};
      carry   = acc_sum[ACC_W];
      // Swapping the step only at a wrap (or from standstill) keeps the waveform phase-continuous.
      xfer_ok = tick && pend_q && (carry || (ftw_act_q == '0));

      if (i_en) begin
         div_cnt_d = tick ? '0 : div_cnt_q + DIV_ONE;
      end

      if (tick) begin
         acc_d   = acc_sum[ACC_W-1:0];
         addr_d  = acc_sum[ACC_W-1 -: ADDR_W] + i_phase_ofs;
         valid_d = 1'b1;
         wrap_d  = carry;
      end

      // A write landing on an eligible tick wins; the new word waits for the next eligible tick.
      if (i_ftw_wr) begin
         ftw_shadow_d = i_ftw;
         pend_d       = 1'b1;
      end else if (xfer_ok) begin
         ftw_act_d = ftw_shadow_q;
         pend_d    = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         acc_q        <= '0;
         ftw_act_q    <= '0;
         ftw_shadow_q <= '0;
         div_cnt_q    <= '0;
         addr_q       <= '0;
         valid_q      <= 1'b0;
         wrap_q       <= 1'b0;
         pend_q       <= 1'b0;
      end else begin
         acc_q        <= acc_d;
         ftw_act_q    <= ftw_act_d;
         ftw_shadow_q <= ftw_shadow_d;
         div_cnt_q    <= div_cnt_d;
         addr_q       <= addr_d;
         valid_q      <= valid_d;
         wrap_q       <= wrap_d;
         pend_q       <= pend_d;
      end
   end

   assign o_addr     = addr_q;
   assign o_valid    = valid_q;
   assign o_wrap     = wrap_q;
   assign o_ftw_pend = pend_q;

endmodule

// File: tb/tb_sine_phase_gen.sv
// Directed bench for sine_phase_gen: stepping, divider cadence, enable hold, phase
// offset, deferred tuning-word updates and mid-period reset.
module tb_sine_phase_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [31:0] ftw;
   logic        ftw_wr;
   logic [9:0]  phase_ofs;
   logic [15:0] div;
   logic [9:0]  addr;
   logic        valid;
   logic        wrap;
   logic        ftw_pend;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   sine_phase_gen #(.ACC_W(32), .ADDR_W(10), .DIV_W(16)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_en        (en),
      .i_ftw       (ftw),
      .i_ftw_wr    (ftw_wr),
      .i_phase_ofs (phase_ofs),
      .i_div       (div),
      .o_addr      (addr),
      .o_valid     (valid),
      .o_wrap      (wrap),
      .o_ftw_pend  (ftw_pend)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance one clock and settle just after the edge.
   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string tag, input int exp_addr, input int exp_valid,
                            input int exp_wrap, input int exp_pend);
      check({tag, ".addr"},  32'(addr),     32'(exp_addr));
      check({tag, ".valid"}, 32'(valid),    32'(exp_valid));
      check({tag, ".wrap"},  32'(wrap),     32'(exp_wrap));
      check({tag, ".pend"},  32'(ftw_pend), 32'(exp_pend));
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; ftw = '0; ftw_wr = 1'b0; phase_ofs = '0; div = '0;
      cycle();
      cycle();
      check_out("reset", 0, 0, 0, 0);
      rst = 1'b0;

      // Basic stepping: write FTW while idle, then enable with divide-by-1.
      ftw = 32'h0040_0000; ftw_wr = 1'b1;
      cycle();
      check_out("wr_idle", 0, 0, 0, 1);
      ftw_wr = 1'b0; en = 1'b1;
      cycle();
      check_out("first_tick", 0, 1, 0, 0);
      for (int n = 1; n <= 1023; n++) begin
         cycle();
         check_out("step1", n, 1, 0, 0);
      end
      cycle();
      check_out("wrap1", 0, 1, 1, 0);

      // Divide-by-4 cadence.
      div = 16'd3;
      for (int i = 1; i <= 12; i++) begin
         cycle();
         check("div4.valid", 32'(valid), 32'((i % 4) == 0));
         check("div4.addr",  32'(addr),  32'(i / 4));
      end
      // Enable low: everything holds.
      en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cycle();
         check("hold.valid", 32'(valid), 32'(0));
         check("hold.addr",  32'(addr),  32'(3));
      end
      en = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         cycle();
         check("resume.valid", 32'(valid), 32'((i % 4) == 0));
         check("resume.addr",  32'(addr),  32'(3 + i / 4));
      end

      // Phase offset of 256 at divide-by-1; accumulator top is 5 here.
      div = 16'd0; phase_ofs = 10'd256;
      for (int n = 6; n <= 1023; n++) begin
         cycle();
         check("ofs.addr", 32'(addr), 32'((n + 256) % 1024));
      end
      cycle();
      check_out("ofs_wrap", 256, 1, 1, 0);

      // Deferred FTW change written when the address reads 100.
      phase_ofs = '0;
      for (int n = 1; n <= 100; n++) begin
         cycle();
         check("pre_wr.addr", 32'(addr), 32'(n));
      end
      ftw = 32'h0080_0000; ftw_wr = 1'b1;
      cycle();
      ftw_wr = 1'b0;
      check_out("wr_run", 101, 1, 0, 1);
      for (int n = 102; n <= 1023; n++) begin
         cycle();
         check("pend_step.addr", 32'(addr), 32'(n));
         check("pend_step.pend", 32'(ftw_pend), 32'(1));
      end
      cycle();
      check_out("apply_wrap", 0, 1, 1, 0);
      for (int j = 1; j <= 5; j++) begin
         cycle();
         check("step2.addr", 32'(addr), 32'(2 * j));
      end

      // Write coinciding with the wrap tick: old step runs one more full period.
      for (int k = 6; k <= 511; k++) begin
         cycle();
         check("to_wrap.addr", 32'(addr), 32'(2 * k));
      end
      ftw = 32'h0040_0000; ftw_wr = 1'b1;
      cycle();
      ftw_wr = 1'b0;
      check_out("coinc_wrap", 0, 1, 1, 1);
      for (int k = 1; k <= 511; k++) begin
         cycle();
         check("coinc_old.addr", 32'(addr), 32'(2 * k));
         check("coinc_old.pend", 32'(ftw_pend), 32'(1));
      end
      cycle();
      check_out("coinc_apply", 0, 1, 1, 0);
      cycle();
      check_out("coinc_new", 1, 1, 0, 0);

      // Reset mid-period with a write pending; a simultaneous write must lose to reset.
      ftw = 32'h0080_0000; ftw_wr = 1'b1;
      cycle();
      ftw_wr = 1'b0;
      check_out("pre_rst", 2, 1, 0, 1);
      rst = 1'b1; ftw_wr = 1'b1;
      cycle();
      rst = 1'b0; ftw_wr = 1'b0;
      check_out("mid_rst", 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         cycle();
         check_out("post_rst", 0, 1, 0, 0);
      end

      // Lowering the divider below the running count ticks on the next enabled cycle.
      div = 16'd5;
      cycle();
      check("div_lower.pre1", 32'(valid), 32'(0));
      cycle();
      check("div_lower.pre2", 32'(valid), 32'(0));
      div = 16'd1;
      cycle();
      check("div_lower.tick", 32'(valid), 32'(1));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
